max1270_scan_ctrl: RTL and testbench
====================================

# max1270_scan_ctrl

Parametrised scanning controller for a MAX1270-class serial multi-channel ADC. It cycles through a run-time channel mask, sending a per-channel control byte (range/bipolar selectable) over SPI and waiting for SSTRB, with a timeout. Each result is read MSB-first and published both as a per-sample stream and as a per-channel register bank. It replaces the fixed 8-channel free-running PHY and sits between the ADC pins and the AXI-Lite register block.

## Interface
- CLK_DIV, 50: clk cycles per SCK half-period; legal range 4..255.
- NUM_CH, 8: number of channels; legal range 1..8.
- DATA_W, 12: result bits clocked out per conversion.
- TIMEOUT_BP, 16: bit periods to wait for SSTRB before aborting.
- GAP_BP, 2: bit periods CS is held high between frames; minimum 1.
- CTRL_PD, 2'b01: PD1/PD0 field of the control byte.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  continuous-scan enable (level).
- start  in  1  single-scan request (1-clk pulse).
- ch_mask  in  NUM_CH  channel enables; latched at scan start.
- rng_bip  in  2*NUM_CH  {rng,bip} for channel i at bits [2i+1:2i]; sampled when that channel's frame begins.
- busy  out  1  scan in progress.
- sample_valid  out  1  1-clk strobe: new result.
- sample_ch  out  3  channel index of the result.
- sample_data  out  DATA_W  result value.
- ch_data  out  NUM_CH*DATA_W  last good result per channel; channel i at [i*DATA_W +: DATA_W].
- scan_done  out  1  1-clk strobe at end of each scan.
- timeout_err  out  1  1-clk strobe when a conversion times out.
- spi_sck, spi_mosi, spi_cs_n, spi_shdn_n  out  1 each  ADC pins.
- spi_miso, spi_sstrb  in  1 each  ADC pins, asynchronous.

## Operation
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, spi_shdn_n=1 (constant), busy=0, all strobes 0, sample_ch=0, sample_data=0, ch_data all 0, FSM=IDLE.
- spi_miso and spi_sstrb each pass through a 2-flop synchronizer before use.
- Bit period (bp) is 2*CLK_DIV clks: SCK is low for the first half and high for the second. MOSI updates on the first clk of the bp. MISO is sampled on the last clk of the high half.
- States: IDLE, SETUP, CTRL, CONV, READ, GAP.
- IDLE: if (start or en) and the live ch_mask is nonzero, latch the mask, set busy=1, select the lowest enabled channel, and go to SETUP. A zero mask means the request is ignored.
- SETUP (1 bp): cs_n=0, SCK held low.
- CTRL (8 bp): MOSI sends {1, ch[2:0], rng, bip, CTRL_PD} MSB first.
- CONV: SCK held low, MOSI=0. Go to READ on the first bp boundary where synchronized SSTRB=1.
  - If SSTRB has not risen after TIMEOUT_BP bp: pulse timeout_err, leave ch_data unchanged, no sample_valid, go to GAP.
- READ (DATA_W bp): shift in MSB first. One clk after the last sample: sample_valid=1, sample_ch/sample_data updated, ch_data slice written.
- GAP (GAP_BP bp): cs_n=1, SCK=0. Then advance to the next higher enabled channel in the latched mask and go to SETUP. If none remains, pulse scan_done and do the following:
  - if en=1 and ch_mask is nonzero, relatch and restart at the lowest channel;
  - otherwise set busy=0 and go to IDLE.
- start while busy is ignored. Dropping en mid-scan completes the current scan. Changing the mask mid-scan takes effect at the next scan.
- Channel indices at or above NUM_CH never exist; their mask bits are not present.
- rst mid-frame returns every output to its reset value on the next clk; the partial frame is discarded.

## Timing
- Frame length in clks = 2*CLK_DIV*(1 + 8 + k + DATA_W + GAP_BP), where k = number of CONV bp (at least 1).
- Start-to-CS-low latency: 1 clk after the start/en is seen in IDLE.
- sample_valid fires 1 clk after the final MISO sample. scan_done fires in the same clk GAP ends for the last channel.
- timeout_err coincides with the CONV→GAP transition.
- scan_done and sample_valid never coincide.

## Test plan
- CLK_DIV=4, mask=8'h05, rng_bip ch2=2'b10, start pulse; model returns SSTRB after 3 bp and data 12'hA5C (ch0) then 12'h3F1 (ch2) -> MOSI bytes 0x81 then 0xA9; sample_valid twice with (0,A5C) then (2,3F1); ch_data slices 0 and 2 set, others 0; one scan_done; busy falls after it.
- en=1, mask=8'h80 -> back-to-back ch7 frames separated by exactly GAP_BP bp of cs_n=1, with scan_done after each; drop en -> the current frame completes, then IDLE.
- SSTRB held low on ch1 -> timeout_err after 16 bp; ch_data[1] keeps its old value; the scan continues to the next enabled channel.
- mask=0 with start and with en=1 -> busy stays 0 and cs_n stays 1.
- start pulsed during READ -> ignored; the frame count equals one scan.
- rst asserted mid-READ -> next clk cs_n=1, sck=0, ch_data=0, busy=0, and no sample_valid.

Source files
------------

// File: rtl/max1270_scan_ctrl.sv
// Scanning controller for a MAX1270-class serial ADC: walks a latched channel mask,
// sends one control byte per channel, waits for SSTRB, reads the result MSB-first.
module max1270_scan_ctrl #(
  parameter int         CLK_DIV    = 50,
  parameter int         NUM_CH     = 8,
  parameter int         DATA_W     = 12,
  parameter int         TIMEOUT_BP = 16,
  parameter int         GAP_BP     = 2,
  parameter logic [1:0] CTRL_PD    = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [2*NUM_CH-1:0]      rng_bip,
  output logic                     busy,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
  output logic [DATA_W-1:0]        sample_data,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     scan_done,
  output logic                     timeout_err,
  output logic                     spi_sck,
  output logic                     spi_mosi,
  output logic                     spi_cs_n,
  output logic                     spi_shdn_n,
  input  logic                     spi_miso,
  input  logic                     spi_sstrb
);
  localparam int BP  = 2 * CLK_DIV;
  localparam int DVW = $clog2(BP);
  localparam int BCW = 16;

  typedef enum logic [2:0] {IDLE, SETUP, CTRL, CONV, READ, GAP} state_t;
  state_t state, state_nxt;

  logic [DVW-1:0]    div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [2:0]        ch, sel_ch;
  logic [1:0]        rb_q;
  logic [DATA_W-2:0] shift_q;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        miso_sync, sstrb_sync;
  logic [3:0]        nxt_hit, first_hit;
  logic [7:0]        ctrl_byte;
  logic miso_s, sstrb_s, bp_end, last_bp, req, restart, load_ch, fresh;

  // {found, index} of the lowest set mask bit at or above 'from'
  function automatic logic [3:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, 3'(i)};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_sync  <= '0;
      sstrb_sync <= '0;
    end else begin
      miso_sync  <= {miso_sync[0], spi_miso};
      sstrb_sync <= {sstrb_sync[0], spi_sstrb};
    end
  end

  assign miso_s    = miso_sync[1];
  assign sstrb_s   = sstrb_sync[1];
  assign bp_end    = (div_cnt == DVW'(BP-1));
  assign nxt_hit   = find_ch(mask_q, int'(ch) + 1);
  assign first_hit = find_ch(ch_mask, 0);
  assign req       = (start | en) & first_hit[3];
  assign restart   = en & first_hit[3];
  assign rd_word   = {shift_q, miso_s};
  assign ctrl_byte = {1'b1, ch, rb_q, CTRL_PD};

  always_comb begin
    case (state)
      SETUP:   last_bp = 1'b1;
      CTRL:    last_bp = (bit_cnt == BCW'(7));
      CONV:    last_bp = (bit_cnt == BCW'(TIMEOUT_BP-1));
      READ:    last_bp = (bit_cnt == BCW'(DATA_W-1));
      GAP:     last_bp = (bit_cnt == BCW'(GAP_BP-1));
      default: last_bp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req) state_nxt = SETUP;
      SETUP: if (bp_end) state_nxt = CTRL;
      CTRL:  if (bp_end && last_bp) state_nxt = CONV;
      CONV: begin
        if (bp_end && sstrb_s)      state_nxt = READ;
        else if (bp_end && last_bp) state_nxt = GAP;
      end
      READ:  if (bp_end && last_bp) state_nxt = GAP;
      GAP:   if (bp_end && last_bp) state_nxt = (nxt_hit[3] || restart) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    spi_cs_n    = (state == IDLE) || (state == GAP);
    spi_sck     = ((state == CTRL) || (state == READ)) && (div_cnt >= DVW'(CLK_DIV));
    spi_mosi    = (state == CTRL) ? ctrl_byte[~bit_cnt[2:0]] : 1'b0;
    spi_shdn_n  = 1'b1;
    timeout_err = (state == CONV) && bp_end && !sstrb_s && last_bp;
    scan_done   = (state == GAP) && bp_end && last_bp && !nxt_hit[3];
  end

  // A frame starts on sel_ch; a fresh scan also relatches the live mask
  always_comb begin
    load_ch = (state_nxt == SETUP) && (state != SETUP);
    fresh   = !((state == GAP) && nxt_hit[3]);
    sel_ch  = fresh ? first_hit[2:0] : nxt_hit[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      mask_q       <= '0;
      ch           <= '0;
      rb_q         <= '0;
      shift_q      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      ch_data      <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (state_nxt != state || state == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (bp_end) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + BCW'(1);
      end else begin
        div_cnt <= div_cnt + DVW'(1);
      end
      if (load_ch) begin
        ch   <= sel_ch;
        rb_q <= rng_bip[int'(sel_ch)*2 +: 2];
        if (fresh) mask_q <= ch_mask;
      end
      if (state == READ && bp_end) begin
        shift_q <= rd_word[DATA_W-2:0];
        if (last_bp) begin
          sample_valid                       <= 1'b1;
          sample_ch                          <= ch;
          sample_data                        <= rd_word;
          ch_data[int'(ch)*DATA_W +: DATA_W] <= rd_word;
        end
      end
    end
  end
endmodule

// File: tb/tb_max1270_scan_ctrl.sv
// Bench for max1270_scan_ctrl: pin-level ADC model plus a per-scan reference of
// expected control bytes, frame lengths, samples and the channel register bank.
module tb_max1270_scan_ctrl;
  localparam int         CLK_DIV    = 4;
  localparam int         NUM_CH     = 8;
  localparam int         DATA_W     = 12;
  localparam int         TIMEOUT_BP = 16;
  localparam int         GAP_BP     = 2;
  localparam logic [1:0] CTRL_PD    = 2'b01;
  localparam int         BP         = 2 * CLK_DIV;

  logic clk = 0, rst = 1, en = 0, start = 0;
  logic [NUM_CH-1:0]   ch_mask = '0;
  logic [2*NUM_CH-1:0] rng_bip = '0;
  logic busy, sample_valid, scan_done, timeout_err;
  logic spi_sck, spi_mosi, spi_cs_n, spi_shdn_n;
  logic spi_miso = 0, spi_sstrb = 0;
  logic [2:0]               sample_ch;
  logic [DATA_W-1:0]        sample_data;
  logic [NUM_CH*DATA_W-1:0] ch_data;

  always #5 clk = ~clk;

  max1270_scan_ctrl #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .TIMEOUT_BP(TIMEOUT_BP), .GAP_BP(GAP_BP), .CTRL_PD(CTRL_PD)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .ch_mask(ch_mask), .rng_bip(rng_bip),
    .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .ch_data(ch_data), .scan_done(scan_done), .timeout_err(timeout_err),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_shdn_n(spi_shdn_n),
    .spi_miso(spi_miso), .spi_sstrb(spi_sstrb));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC behaviour: per-channel result and SSTRB delay in bit periods (-1 = never)
  logic [DATA_W-1:0] adc_val [NUM_CH];
  int                sstrb_dly [NUM_CH];
  logic [DATA_W-1:0] exp_data [NUM_CH];

  int nrise = 0, conv_t = -1, cs_len = 0, gap_cnt = 0, cur_dly = -1;
  logic [7:0] ctrl_sh = '0;
  logic [DATA_W-1:0] cur_val = '0;
  logic sck_prev = 0, cs_prev = 1;
  logic [7:0] frm_byte[$];
  int frm_len[$], gap_q[$];
  logic [2:0] smp_ch[$];
  logic [DATA_W-1:0] smp_dat[$];
  int done_cnt = 0, to_cnt = 0, clash_cnt = 0, busy_seen = 0, cs_seen = 0;

  always @(negedge clk) begin
    if (spi_cs_n) begin
      if (!cs_prev) begin
        frm_byte.push_back(ctrl_sh);
        frm_len.push_back(cs_len);
      end
      nrise = 0; conv_t = -1; cs_len = 0; ctrl_sh = '0;
      spi_sstrb = 0; spi_miso = 0;
      if (busy) gap_cnt++; else gap_cnt = 0;
    end else begin
      if (cs_prev && gap_cnt > 0) gap_q.push_back(gap_cnt);
      gap_cnt = 0;
      cs_len++;
      if (spi_sck && !sck_prev) begin
        nrise++;
        if (nrise <= 8) ctrl_sh = {ctrl_sh[6:0], spi_mosi};
        if (nrise == 8) begin
          cur_val = adc_val[ctrl_sh[6:4]];
          cur_dly = sstrb_dly[ctrl_sh[6:4]];
        end
      end
      if (!spi_sck && sck_prev && nrise == 8) conv_t = 0;
      else if (conv_t >= 0) conv_t++;
      if (nrise == 8 && cur_dly >= 0 && conv_t == cur_dly * BP) begin
        spi_sstrb = 1;
        spi_miso  = cur_val[DATA_W-1];
      end
      if (!spi_sck && sck_prev && nrise > 8 && nrise - 8 < DATA_W)
        spi_miso = cur_val[DATA_W-1-(nrise-8)];
    end
    sck_prev = spi_sck;
    cs_prev  = spi_cs_n;
    if (sample_valid) begin
      smp_ch.push_back(sample_ch);
      smp_dat.push_back(sample_data);
    end
    if (scan_done) done_cnt++;
    if (timeout_err) to_cnt++;
    if (sample_valid && scan_done) clash_cnt++;
    if (busy) busy_seen++;
    if (!spi_cs_n) cs_seen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    frm_byte.delete(); frm_len.delete(); gap_q.delete();
    smp_ch.delete(); smp_dat.delete();
    done_cnt = 0; to_cnt = 0; clash_cnt = 0; busy_seen = 0; cs_seen = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) chk("idle_wait_expired", busy, 0);
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] packed_exp();
    logic [NUM_CH*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = exp_data[i];
    return v;
  endfunction

  // One start-triggered scan, checked frame by frame against the reference
  task automatic run_scan(input logic [NUM_CH-1:0] m);
    int chs[$];
    int nsmp, nto, c, d, k;
    logic [7:0] eb;
    nsmp = 0; nto = 0;
    clear_obs();
    for (int i = 0; i < NUM_CH; i++) if (m[i]) chs.push_back(i);
    ch_mask = m; start = 1; tick(); start = 0;
    chk("busy_rise", busy, 1);
    chk("cs_latency", spi_cs_n, 0);
    wait_idle(6000);
    chk("n_frames", frm_byte.size(), chs.size());
    chk("n_scan_done", done_cnt, 1);
    for (int i = 0; i < chs.size() && i < frm_byte.size(); i++) begin
      c  = chs[i];
      d  = sstrb_dly[c];
      eb = {1'b1, 3'(c), rng_bip[2*c+1], rng_bip[2*c], CTRL_PD};
      chk($sformatf("ctrl_byte[%0d]", i), frm_byte[i], eb);
      k  = (d < 0) ? TIMEOUT_BP : d + 1;
      chk($sformatf("frame_len[%0d]", i), frm_len[i], BP * (1 + 8 + k + ((d < 0) ? 0 : DATA_W)));
      if (d < 0) nto++;
      else begin
        if (nsmp < smp_ch.size()) begin
          chk($sformatf("sample_ch[%0d]", i), smp_ch[nsmp], c);
          chk($sformatf("sample_data[%0d]", i), smp_dat[nsmp], adc_val[c]);
        end
        nsmp++;
        exp_data[c] = adc_val[c];
      end
    end
    chk("n_samples", smp_ch.size(), nsmp);
    chk("n_timeouts", to_cnt, nto);
    chk("ch_data", ch_data, packed_exp());
    chk("valid_done_clash", clash_cnt, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [DATA_W-1:0] old;
    for (int i = 0; i < NUM_CH; i++) begin adc_val[i] = '0; sstrb_dly[i] = 0; exp_data[i] = '0; end

    repeat (3) tick();
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_shdn_n", spi_shdn_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {sample_valid, scan_done, timeout_err}, 0);
    chk("rst_sample", {sample_ch, sample_data}, 0);
    chk("rst_ch_data", ch_data, 0);
    rst = 0; tick();

    // directed scan: ch0 and ch2
    rng_bip = 16'h0020;
    adc_val[0] = 12'hA5C; adc_val[2] = 12'h3F1;
    sstrb_dly[0] = 2; sstrb_dly[2] = 2;
    run_scan(8'h05);
    if (frm_byte.size() == 2) begin
      chk("tp_byte0", frm_byte[0], 8'h81);
      chk("tp_byte1", frm_byte[1], 8'hA9);
    end else chk("tp_frames", frm_byte.size(), 2);
    chk("tp_slice0", ch_data[0 +: DATA_W], 12'hA5C);
    chk("tp_slice2", ch_data[2*DATA_W +: DATA_W], 12'h3F1);
    chk("tp_busy_low", busy, 0);

    // random scans
    for (int s = 0; s < 6; s++) begin
      rng_bip = 16'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        adc_val[i]   = DATA_W'($urandom);
        sstrb_dly[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT_BP-2));
      end
      run_scan(8'($urandom_range(1, 255)));
    end

    // timeout on ch1 keeps its previous result
    for (int i = 0; i < NUM_CH; i++) sstrb_dly[i] = 1;
    run_scan(8'h03);
    old = exp_data[1];
    adc_val[1] = ~old;
    sstrb_dly[1] = -1;
    run_scan(8'h03);
    chk("to_hold_ch1", ch_data[DATA_W +: DATA_W], old);
    chk("to_count", to_cnt, 1);

    // continuous scanning on ch7, then drop en mid-frame
    clear_obs();
    sstrb_dly[7] = 1;
    ch_mask = 8'h80; en = 1;
    n = 0;
    while (done_cnt < 3 && n < 3000) begin tick(); n++; end
    chk("en_three_scans", done_cnt >= 3, 1);
    repeat (20) tick();
    en = 0;
    wait_idle(2000);
    chk("en_scan_done", done_cnt, 4);
    chk("en_frames", frm_byte.size(), 4);
    chk("en_samples", smp_ch.size(), 4);
    chk("en_gaps", gap_q.size(), 3);
    foreach (gap_q[i]) chk($sformatf("en_gap[%0d]", i), gap_q[i], GAP_BP * BP);
    foreach (frm_byte[i]) chk($sformatf("en_byte[%0d]", i), frm_byte[i],
                              {1'b1, 3'd7, rng_bip[15], rng_bip[14], CTRL_PD});

    // zero mask: neither start nor en starts a scan
    clear_obs();
    ch_mask = '0; start = 1; tick(); start = 0;
    en = 1; repeat (40) tick(); en = 0; tick();
    chk("zero_mask_busy", busy_seen, 0);
    chk("zero_mask_cs", cs_seen, 0);

    // start during READ is ignored
    clear_obs();
    sstrb_dly[1] = 0; adc_val[1] = 12'h5A3;
    ch_mask = 8'h02; start = 1; tick(); start = 0;
    n = 0;
    while (nrise < 12 && n < 600) begin tick(); n++; end
    chk("reach_read", nrise >= 12, 1);
    start = 1; tick(); start = 0;
    wait_idle(2000);
    repeat (60) tick();
    chk("busy_start_frames", frm_byte.size(), 1);
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_idle", busy, 0);
    exp_data[1] = 12'h5A3;

    // reset in the middle of READ
    clear_obs();
    sstrb_dly[0] = 0;
    ch_mask = 8'h01; start = 1; tick(); start = 0;
    n = 0;
    while (nrise < 12 && n < 600) begin tick(); n++; end
    chk("rst_reach_read", nrise >= 12, 1);
    rst = 1; tick();
    chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_sck", spi_sck, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ch_data", ch_data, 0);
    chk("midrst_valid", sample_valid, 0);
    rst = 0;
    repeat (200) tick();
    chk("midrst_no_sample", smp_ch.size(), 0);
    chk("midrst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
